decoder_6b5b: RTL and testbench

DECODER_6B5B -- requirements
Module: decoder_6b5b

---
 rtl/codec_5b6b_pkg.sv | 51 +++++
 rtl/decoder_6b5b_lut.sv | 96 +++++++++
 rtl/decoder_6b5b.sv | 122 ++++++++++++
 tb/tb_decoder_6b5b.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/codec_5b6b_pkg.sv
// ============================================================================
// Module      : codec_5b6b_pkg
// Description : Shared types and constants for the 5b/6b encoder/decoder pair:
//               running-disparity type, symbol classes, bit-order indices of
//               the 6b symbol (abcdei) and the K.28 6b codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package codec_5b6b_pkg;

   // Running disparity state
   typedef enum logic {
      RD_NEG = 1'b0,
      RD_POS = 1'b1
   } rd_e;

   // Disparity class of a received 6b symbol
   typedef enum logic [1:0] {
      CLS_NEUTRAL = 2'd0,
      CLS_POS     = 2'd1,
      CLS_NEG     = 2'd2,
      CLS_INVALID = 2'd3
   } cls_e;

   // Bit positions of the 6b line symbol on the parallel bus
   localparam int c_BIT_A = 0;
   localparam int c_BIT_B = 1;
   localparam int c_BIT_C = 2;
   localparam int c_BIT_D = 3;
   localparam int c_BIT_E = 4;
   localparam int c_BIT_I = 5;

   // K.28 6b codes, written in transmission order abcdei
   localparam logic [5:0] c_K28_RDN  = 6'b001111;
   localparam logic [5:0] c_K28_RDP  = 6'b110000;
   localparam logic [4:0] c_K28_DATA = 5'b11100;

   // Number of ones in a 6b symbol
   function automatic logic [2:0] ones6(input logic [5:0] sym);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int k = 0; k < 6; k++) begin
         cnt = cnt + {2'b00, sym[k]};
      end
      return cnt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_6b5b_lut.sv
// ============================================================================
// Module      : decoder_6b5b_lut
// Description : Combinational 6b->5b lookup: decoded EDCBA, table hit, K.28
//               flag, ones-count class and per-RD legality of the symbol.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_6b5b_lut
   import codec_5b6b_pkg::*;
(
   input  logic [5:0] i_data_in,
   output logic [4:0] o_data,
   output logic       o_hit,
   output logic       o_k28,
   output cls_e       o_cls,
   output logic       o_bad_in_neg,
   output logic       o_bad_in_pos
);

   // Neutral D.7 codes: each is only legal under one running disparity
   localparam logic [5:0] c_D7_RDN = 6'b111000;
   localparam logic [5:0] c_D7_RDP = 6'b000111;

   logic [5:0] w_abcdei;
   logic [2:0] w_ones;

   assign w_abcdei = {i_data_in[c_BIT_A], i_data_in[c_BIT_B], i_data_in[c_BIT_C],
                      i_data_in[c_BIT_D], i_data_in[c_BIT_E], i_data_in[c_BIT_I]};
   assign w_ones   = ones6(w_abcdei);

   // Table lookup; both RD variants of each code map to the same data value
   always_comb begin
      o_data = 5'd0;
      o_hit  = 1'b1;
      o_k28  = 1'b0;
      case (w_abcdei)
         6'b100111, 6'b011000: o_data = 5'd0;
         6'b011101, 6'b100010: o_data = 5'd1;
         6'b101101, 6'b010010: o_data = 5'd2;
         6'b110001:            o_data = 5'd3;
         6'b110101, 6'b001010: o_data = 5'd4;
         6'b101001:            o_data = 5'd5;
         6'b011001:            o_data = 5'd6;
         c_D7_RDN, c_D7_RDP:   o_data = 5'd7;
         6'b111001, 6'b000110: o_data = 5'd8;
         6'b100101:            o_data = 5'd9;
         6'b010101:            o_data = 5'd10;
         6'b110100:            o_data = 5'd11;
         6'b001101:            o_data = 5'd12;
         6'b101100:            o_data = 5'd13;
         6'b011100:            o_data = 5'd14;
         6'b010111, 6'b101000: o_data = 5'd15;
         6'b011011, 6'b100100: o_data = 5'd16;
         6'b100011:            o_data = 5'd17;
         6'b010011:            o_data = 5'd18;
         6'b110010:            o_data = 5'd19;
         6'b001011:            o_data = 5'd20;
         6'b101010:            o_data = 5'd21;
         6'b011010:            o_data = 5'd22;
         6'b111010, 6'b000101: o_data = 5'd23;
         6'b110011, 6'b001100: o_data = 5'd24;
         6'b100110:            o_data = 5'd25;
         6'b010110:            o_data = 5'd26;
         6'b110110, 6'b001001: o_data = 5'd27;
         6'b001110:            o_data = 5'd28;
         6'b101110, 6'b010001: o_data = 5'd29;
         6'b011110, 6'b100001: o_data = 5'd30;
         6'b101011, 6'b010100: o_data = 5'd31;
         c_K28_RDN, c_K28_RDP: begin
            o_data = c_K28_DATA;
            o_k28  = 1'b1;
         end
         default:              o_hit  = 1'b0;
      endcase
   end

   // Disparity class from the ones count (table hits only have 2, 3 or 4 ones)
   always_comb begin
      o_cls = CLS_INVALID;
      if (o_hit) begin
         case (w_ones)
            3'd4:    o_cls = CLS_POS;
            3'd2:    o_cls = CLS_NEG;
            default: o_cls = CLS_NEUTRAL;
         endcase
      end
   end

   // Symbols that cannot legally follow the given running disparity
   assign o_bad_in_neg = o_hit && ((o_cls == CLS_NEG) || (w_abcdei == c_D7_RDP));
   assign o_bad_in_pos = o_hit && ((o_cls == CLS_POS) || (w_abcdei == c_D7_RDN));

endmodule

`default_nettype wire

// File: rtl/decoder_6b5b.sv
// ============================================================================
// Module      : decoder_6b5b
// Description : 6b/5b decoder with running-disparity tracking, code and
//               disparity error detection, one-cycle registered outputs.
//               Optional error counter enabled by DECODER_6B5B_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_6b5b
   import codec_5b6b_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_data_in,
   input  logic       i_enb,
   input  logic       i_rd_in,
   input  logic       i_rd_ld,
   output logic [4:0] o_data_out,
   output logic       o_rd_out,
   output logic       o_valid,
   output logic       o_k28,
   output logic       o_code_err,
   output logic       o_disp_err
`ifdef DECODER_6B5B_ERR_CNT_EN
   ,
   output logic [7:0] o_err_cnt
`endif
);

   rd_e        r_rd;
   rd_e        w_rd_cur;
   rd_e        w_rd_next;
   logic [4:0] w_lut_data;
   logic       w_lut_hit;
   logic       w_lut_k28;
   cls_e       w_lut_cls;
   logic       w_bad_in_neg;
   logic       w_bad_in_pos;
   logic [4:0] w_data_d;
   logic       w_k28_d;
   logic       w_code_err_d;
   logic       w_disp_err_d;

   decoder_6b5b_lut u_lut (
      .i_data_in    (i_data_in),
      .o_data       (w_lut_data),
      .o_hit        (w_lut_hit),
      .o_k28        (w_lut_k28),
      .o_cls        (w_lut_cls),
      .o_bad_in_neg (w_bad_in_neg),
      .o_bad_in_pos (w_bad_in_pos)
   );

   // A load in the same cycle replaces the RD the symbol is checked against
   assign w_rd_cur = i_rd_ld ? rd_e'(i_rd_in) : r_rd;

   // RD state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_rd <= RD_NEG;
      else       r_rd <= w_rd_next;
   end

   // RD next state: unbalanced symbols set RD, neutral and invalid keep it
   always_comb begin
      w_rd_next = w_rd_cur;
      if (i_enb) begin
         case (w_lut_cls)
            CLS_POS: w_rd_next = RD_POS;
            CLS_NEG: w_rd_next = RD_NEG;
            default: w_rd_next = w_rd_cur;
         endcase
      end
   end

   // Decode results for the symbol on the bus this cycle
   always_comb begin
      w_code_err_d = !w_lut_hit;
      w_data_d     = w_lut_hit ? w_lut_data : 5'd0;
      w_k28_d      = w_lut_hit && w_lut_k28;
      w_disp_err_d = (w_rd_cur == RD_POS) ? w_bad_in_pos : w_bad_in_neg;
   end

   // Output registers; results held while no symbol is accepted
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid    <= 1'b0;
         o_data_out <= 5'd0;
         o_k28      <= 1'b0;
         o_code_err <= 1'b0;
         o_disp_err <= 1'b0;
      end else begin
         o_valid <= i_enb;
         if (i_enb) begin
            o_data_out <= w_data_d;
            o_k28      <= w_k28_d;
            o_code_err <= w_code_err_d;
            o_disp_err <= w_disp_err_d;
         end
      end
   end

   assign o_rd_out = r_rd;

`ifdef DECODER_6B5B_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   // Saturating count of accepted symbols carrying any error
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err_cnt <= 8'd0;
      end else if (i_enb && (w_code_err_d || w_disp_err_d) && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign o_err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_6b5b.sv
// ============================================================================
// Module      : tb_decoder_6b5b
// Description : Self-checking bench for decoder_6b5b. Expected results come
//               from an independent table model and travel through a queue.
//               Build with DECODER_6B5B_ERR_CNT_EN to also check o_err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_6b5b;

   typedef struct packed {
      logic [4:0] data;
      logic       k28;
      logic       code;
      logic       disp;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [5:0] data_in;
   logic       enb;
   logic       rd_in;
   logic       rd_ld;
   logic [4:0] data_out;
   logic       rd_out;
   logic       valid;
   logic       k28;
   logic       code_err;
   logic       disp_err;
`ifdef DECODER_6B5B_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int   n_tests;
   int   n_fail;
   exp_t q_exp[$];
   exp_t last_exp;
   logic m_rd;
   int   m_cnt;

   // RD- and RD+ codes of D.0..D.31 in abcdei order
   logic [5:0] tbl_n [32];
   logic [5:0] tbl_p [32];

   decoder_6b5b dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_data_in  (data_in),
      .i_enb      (enb),
      .i_rd_in    (rd_in),
      .i_rd_ld    (rd_ld),
      .o_data_out (data_out),
      .o_rd_out   (rd_out),
      .o_valid    (valid),
      .o_k28      (k28),
      .o_code_err (code_err),
      .o_disp_err (disp_err)
`ifdef DECODER_6B5B_ERR_CNT_EN
      ,
      .o_err_cnt  (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle, update the model, then check outputs after the edge
   task automatic cycle(input logic r, input logic e, input logic [5:0] sym,
                        input logic ld, input logic rin);
      logic [5:0] abc;
      logic       in_n;
      logic       in_p;
      logic       cur;
      int         d;
      int         ones;
      exp_t       x;
      exp_t       got;
      @(negedge clk);
      rst = r; enb = e; data_in = sym; rd_ld = ld; rd_in = rin;
      if (r) begin
         q_exp.delete();
         last_exp = '0;
         m_rd     = 1'b0;
         m_cnt    = 0;
      end else begin
         cur = ld ? rin : m_rd;
         if (e) begin
            abc  = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
            in_n = 1'b0;
            in_p = 1'b0;
            d    = 0;
            x    = '0;
            for (int k = 0; k < 32; k++) begin
               if (tbl_n[k] == abc) begin in_n = 1'b1; d = k; end
               if (tbl_p[k] == abc) begin in_p = 1'b1; d = k; end
            end
            if (abc == 6'b001111) begin in_n = 1'b1; d = 28; x.k28 = 1'b1; end
            if (abc == 6'b110000) begin in_p = 1'b1; d = 28; x.k28 = 1'b1; end
            if (!(in_n || in_p)) begin
               x      = '0;
               x.code = 1'b1;
               m_rd   = cur;
            end else begin
               x.data = 5'(d);
               x.disp = cur ? !in_p : !in_n;
               ones   = $countones(abc);
               m_rd   = (ones == 4) ? 1'b1 : (ones == 2) ? 1'b0 : cur;
            end
            if ((x.code || x.disp) && m_cnt < 255) m_cnt++;
            q_exp.push_back(x);
         end else begin
            m_rd = cur;
         end
      end
      @(posedge clk);
      #1;
      got = '{data: data_out, k28: k28, code: code_err, disp: disp_err};
      check("valid", int'(valid), (q_exp.size() > 0) ? 1 : 0);
      if (q_exp.size() > 0) last_exp = q_exp.pop_front();
      check("data_out", int'(got.data), int'(last_exp.data));
      check("k28", int'(got.k28), int'(last_exp.k28));
      check("code_err", int'(got.code), int'(last_exp.code));
      check("disp_err", int'(got.disp), int'(last_exp.disp));
      check("rd_out", int'(rd_out), int'(m_rd));
`ifdef DECODER_6B5B_ERR_CNT_EN
      check("err_cnt", int'(err_cnt), m_cnt);
`endif
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      last_exp = '0;
      m_rd     = 1'b0;
      m_cnt    = 0;
      rst = 1'b1; enb = 1'b0; data_in = 6'd0; rd_ld = 1'b0; rd_in = 1'b0;
      tbl_n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                6'b011110, 6'b101011};
      tbl_p = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                6'b100001, 6'b010100};

      // Reset
      cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);

      // D.0 RD- then D.0 RD+
      cycle(1'b0, 1'b1, 6'b111001, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 6'b000110, 1'b0, 1'b0);
      // D.7 (abcdei 111000) twice in RD-, then D.7 alternate (abcdei 000111) in RD-
      cycle(1'b0, 1'b1, 6'b000111, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 6'b000111, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 6'b111000, 1'b0, 1'b0);
      // Code error: all zeros, RD unchanged
      cycle(1'b0, 1'b1, 6'b000000, 1'b0, 1'b0);
      // K.28 RD-
      cycle(1'b0, 1'b1, 6'b111100, 1'b0, 1'b0);
      // Idle: outputs held, valid low
      cycle(1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
      // RD load without a symbol
      cycle(1'b0, 1'b0, 6'b111111, 1'b1, 1'b0);
      // RD load to RD+ together with a D.0 RD- code
      cycle(1'b0, 1'b1, 6'b111001, 1'b1, 1'b1);
      // D.28 is not K.28; K.28 RD+ after RD+ recovered
      cycle(1'b0, 1'b1, 6'b011100, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 6'b000011, 1'b0, 1'b0);
      // All-ones code error
      cycle(1'b0, 1'b1, 6'b111111, 1'b0, 1'b0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         cycle(1'b0, ($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
               ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end

      // Enough errors to reach counter saturation
      for (int n = 0; n < 260; n++) begin
         cycle(1'b0, 1'b1, 6'b000000, 1'b0, 1'b0);
      end

      // Reset mid-stream drops the in-flight symbol, decoding then resumes
      cycle(1'b0, 1'b1, 6'b111001, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 6'b111001, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 6'b111001, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
